mac_operand_sequencer: RTL
==========================

Name: mac_operand_sequencer

Overview:
- Feeder and collector on the operand side of mac_unit. On start, it streams vec_len operand pairs from a weight buffer and an input buffer into the MAC, then flushes the MAC pipeline.
- It captures the accumulated dot product and returns it through a valid/ready result handshake.
- mac_unit has no accumulator clear, so the sequencer snapshots the accumulator at job start and reports the difference. Each job's result is therefore independent of earlier jobs.

Parameters:
- NUM_W, 8, operand width; must equal the MAC num_width.
- ACC_W, 2*NUM_W+1 (17), width of the MAC result and the result port.
- ADDR_W, 6, buffer address width.
- LEN_W, 7, vec_len width; legal range 0..2**ADDR_W.
- MAC_LAT, 2, cycles from mac_enable+operands to the accumulator update visible on mac_result.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  job request pulse; sampled only in IDLE.
- vec_len  in  LEN_W  number of operand pairs; sampled with start.
- busy  out  1  high from start acceptance until result handoff.
- rd_en  out  1  read strobe to both buffers (registered).
- rd_addr  out  ADDR_W  shared read address (registered).
- w_data  in  NUM_W  weight buffer data; valid 1 cycle after rd_en.
- x_data  in  NUM_W  input buffer data; valid 1 cycle after rd_en.
- mac_enable  out  1  to mac_unit enable (registered).
- mac_num_1  out  NUM_W  weight operand (registered).
- mac_num_2  out  NUM_W  input operand (registered).
- mac_result  in  ACC_W  mac_unit output_num.
- result  out  ACC_W  dot product, unsigned, modulo 2**ACC_W.
- result_valid  out  1  result available.
- result_ready  in  1  downstream accept.

Behaviour:
Reset (reset=0, asynchronous):
- All outputs go to 0 and the FSM goes to IDLE.
- Internal counters, the base register and the data-valid pipeline flag clear.

FSM states: IDLE, STREAM, FLUSH, CAPTURE, HOLD.

IDLE:
- When start=1, latch vec_len and latch base <= mac_result. busy=1 from the next cycle.
- vec_len=0: go to CAPTURE directly; no rd_en, no mac_enable.
- vec_len>0: go to STREAM.
- start in any other state is ignored.

STREAM:
- In stream cycle i (i=0..N-1), rd_en=1 and rd_addr=i.
- Buffer data returns in cycle i+1. It is registered into mac_num_1/2 with mac_enable=1 in cycle i+2.
- After the last address is issued, rd_en drops and the FSM moves to FLUSH.
- Operand stream: mac_enable is high for N consecutive cycles carrying pairs 0..N-1 in order, with no bubbles.

FLUSH:
- Starts after the last real pair has been presented.
- Holds mac_enable=1 with mac_num_1=mac_num_2=0 for MAC_LAT cycles, so products drain and the accumulator is unchanged by the padding.
- mac_enable then drops to 0 and stays low, which freezes the MAC.

CAPTURE (one cycle):
- result <= mac_result - base, modulo 2**ACC_W.
- Wrap-around of the accumulator between snapshot and capture is absorbed by the modular subtraction.
- For vec_len=0, result=0.

HOLD:
- result_valid=1 and result is held stable until result_ready=1.
- On the handshake cycle, result_valid drops on the next edge, busy drops, and the FSM returns to IDLE.
- A start in the same cycle as the handshake is ignored; it must arrive once the FSM is in IDLE.

Latency and arithmetic:
- For N>0, start to result_valid is N+MAC_LAT+4 cycles.
- Operands are unsigned. The maximum single product is 65025. The ACC_W result is exact for sums < 131072, else modular.

Mid-operation reset:
- Aborts immediately: rd_en=0, mac_enable=0, result_valid=0.
- The MAC's own contents are not recovered; the next job re-snapshots base.

Reserved inputs:
- vec_len > 2**ADDR_W is reserved. The address counter wraps modulo 2**ADDR_W; no error is flagged.

Test Plan:
- w=[1,2,3,4], x=[5,6,7,8], vec_len=4, result_ready=1 → result=70, result_valid after 10 cycles (MAC_LAT=2), rd_addr 0..3 in order, exactly 4+2 mac_enable cycles.
- Back-to-back jobs: job1 as above (70), then job2 w=[10,10], x=[3,4] → result=70 then 70; job2 is not 140, which proves base subtraction.
- All 64 entries w=x=255 with 2 prior jobs accumulated → result=(64*65025) mod 131072=98368, correct despite accumulator wrap.
- vec_len=0 → result=0, result_valid 2 cycles after start, rd_en and mac_enable never asserted.
- Backpressure: result_ready held 0 for 5 cycles → result_valid and result stable, busy=1, start pulses ignored; release → single handoff, return to IDLE.
- Assert reset mid-STREAM at pair 2 of 8 → all outputs 0 asynchronously; a following job w=[2], x=[3] → result=6.

Source files
------------

// File: rtl/mac_operand_sequencer_if.sv
// Operand-side bus between mac_operand_sequencer and its buffers, MAC and result consumer.
// slave is the sequencer's view; master is the environment's view.
interface mac_operand_sequencer_if #(
    parameter int NUM_W  = 8,
    parameter int ACC_W  = 2 * NUM_W + 1,
    parameter int ADDR_W = 6,
    parameter int LEN_W  = 7
);
    logic              start;
    logic [LEN_W-1:0]  vec_len;
    logic              busy;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [NUM_W-1:0]  w_data;
    logic [NUM_W-1:0]  x_data;
    logic              mac_enable;
    logic [NUM_W-1:0]  mac_num_1;
    logic [NUM_W-1:0]  mac_num_2;
    logic [ACC_W-1:0]  mac_result;
    logic [ACC_W-1:0]  result;
    logic              result_valid;
    logic              result_ready;

    modport slave (
        input  start, vec_len, w_data, x_data, mac_result, result_ready,
        output busy, rd_en, rd_addr, mac_enable, mac_num_1, mac_num_2, result, result_valid
    );

    modport master (
        output start, vec_len, w_data, x_data, mac_result, result_ready,
        input  busy, rd_en, rd_addr, mac_enable, mac_num_1, mac_num_2, result, result_valid
    );
endinterface

// File: rtl/mac_operand_sequencer.sv
// Streams vec_len weight/input pairs into mac_unit, flushes its pipeline, and returns
// the accumulator delta since job start through a valid/ready result handshake.
module mac_operand_sequencer #(
    parameter int NUM_W   = 8,
    parameter int ACC_W   = 2 * NUM_W + 1,
    parameter int ADDR_W  = 6,
    parameter int LEN_W   = 7,
    parameter int MAC_LAT = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    mac_operand_sequencer_if.slave  bus
);
    localparam int FCNT_W = $clog2(MAC_LAT + 2);
    localparam logic [FCNT_W-1:0] FLUSH_LAST = FCNT_W'(MAC_LAT + 1);

    typedef enum logic [2:0] {IDLE, STREAM, FLUSH, CAPTURE, HOLD} state_t;

    state_t             state;
    logic [LEN_W-1:0]   remaining;
    logic [ACC_W-1:0]   base;
    logic [FCNT_W-1:0]  flush_cnt;
    logic               data_valid;

    // NOTE: every register here is state, so all updates use <= to read pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= IDLE;
            remaining      <= '0;
            base           <= '0;
            flush_cnt      <= '0;
            data_valid     <= 1'b0;
            bus.busy       <= 1'b0;
            bus.rd_en      <= 1'b0;
            bus.rd_addr    <= '0;
            bus.mac_enable <= 1'b0;
            bus.mac_num_1  <= '0;
            bus.mac_num_2  <= '0;
            bus.result     <= '0;
            bus.result_valid <= 1'b0;
        end else begin
            // Buffer data is valid the cycle after rd_en; register it straight into the MAC.
            data_valid <= bus.rd_en;
            if (data_valid) begin
                bus.mac_enable <= 1'b1;
                bus.mac_num_1  <= bus.w_data;
                bus.mac_num_2  <= bus.x_data;
            end else if (state == FLUSH && flush_cnt != FLUSH_LAST) begin
                bus.mac_enable <= 1'b1;
                bus.mac_num_1  <= '0;
                bus.mac_num_2  <= '0;
            end else begin
                bus.mac_enable <= 1'b0;
                bus.mac_num_1  <= '0;
                bus.mac_num_2  <= '0;
            end

            case (state)
                IDLE: begin
                    flush_cnt <= '0;
                    if (bus.start) begin
                        bus.busy <= 1'b1;
                        base     <= bus.mac_result;
                        if (bus.vec_len == '0) begin
                            state <= CAPTURE;
                        end else begin
                            state       <= STREAM;
                            bus.rd_en   <= 1'b1;
                            bus.rd_addr <= '0;
                            remaining   <= bus.vec_len - 1'b1;
                        end
                    end
                end
                STREAM: begin
                    if (remaining == '0) begin
                        bus.rd_en <= 1'b0;
                        state     <= FLUSH;
                    end else begin
                        bus.rd_addr <= bus.rd_addr + 1'b1;
                        remaining   <= remaining - 1'b1;
                    end
                end
                FLUSH: begin
                    // Covers the last data cycle plus MAC_LAT zero pairs, then one idle cycle.
                    if (flush_cnt == FLUSH_LAST) begin
                        state <= CAPTURE;
                    end else begin
                        flush_cnt <= flush_cnt + 1'b1;
                    end
                end
                CAPTURE: begin
                    // Modular difference absorbs any accumulator wrap since the snapshot.
                    bus.result       <= bus.mac_result - base;
                    bus.result_valid <= 1'b1;
                    state            <= HOLD;
                end
                HOLD: begin
                    if (bus.result_ready) begin
                        bus.result_valid <= 1'b0;
                        bus.busy         <= 1'b0;
                        state            <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
